gate_truth_checker: RTL
=======================

Name: gate_truth_checker

Overview:
Self-checking hardware stimulus/response engine for small combinational gates under test. It drives a Gray-code walk of every input vector onto the gate, holds each vector for a configurable settle time, and samples the gate output. Each sample is compared against a parameterised truth table. Error count, first failing vector and a pass flag are reported, so the checks a simulation testbench performs run in synthesised logic on the lab board.

Parameters:
N_IN, 2, number of gate inputs (1..4); 2^N_IN vectors are applied
TRUTH, 4'b1000, expected output per vector, bit i = expected out for input vector i (default = AND; width 2^N_IN)
HOLD_CYCLES, 10, clocks each vector is held before sampling (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a run when idle
dut_out  in  1  output of gate under test
stim  out  N_IN  input vector driven to gate; bit 0 = first input (a), bit 1 = b, ...
busy  out  1  high while a run is in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  1 when last completed run had zero errors; held until next start
err_count  out  8  mismatches in current/last run, saturates at 255
first_fail  out  N_IN  input vector of first mismatch of current/last run
fail_valid  out  1  first_fail holds a valid vector

Behaviour:
- Reset (async assert, sync release): state IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_valid=0; internal index and hold counter = 0.
- States: IDLE, DRIVE, FINISH.
- IDLE: start=1 at edge -> DRIVE; busy=1, index=0, hold_cnt=0, stim=gray(0)=0, err_count=0, fail_valid=0, first_fail=0, pass=0.
- DRIVE: hold_cnt increments every clk. At the edge where hold_cnt==HOLD_CYCLES-1:
  - sample dut_out and compare with TRUTH[stim];
  - mismatch: err_count+1 (saturating at 255); if fail_valid==0, load first_fail=stim and set fail_valid=1;
  - if index==2^N_IN-1 -> FINISH; otherwise index+1, hold_cnt=0, stim=gray(index+1).
- stim = index ^ (index>>1); exactly one stim bit changes per step.
- FINISH (one cycle): done=1, busy=0, stim=0, pass=(final err_count==0); next edge -> IDLE, done=0.
- Timing: start sampled at edge k; busy high from k+1 through k+2^N_IN*HOLD_CYCLES; done high for exactly one cycle, the following cycle. Default parameters: 40 busy cycles.
- start while busy or in FINISH is ignored; there is no queueing.
- Results (pass, err_count, first_fail, fail_valid) hold in IDLE until the next accepted start.
- HOLD_CYCLES=1: sample on the same edge the vector is first held; one vector per clock.
- Reset asserted mid-run aborts immediately to reset values; no done pulse is produced.
- dut_out is assumed synchronous to clk, or registered externally; the block does not synchronise it.

Decomposition:
- Shared package: state encoding constants (IDLE/DRIVE/FINISH) and a gray-encode function, reused by future gate checkers.
- One natural sub-module: hold_timer (counter with terminal-count pulse, parameter HOLD_CYCLES), also reusable for other debounce/settle logic.
- Everything else stays in gate_truth_checker.

Test Plan:
- Correct AND model on stim, HOLD_CYCLES=4, pulse start -> stim sequence 00,01,11,10 each held 4 clks; done at start+17; pass=1, err_count=0, fail_valid=0.
- dut_out stuck-at-0 -> err_count=1, first_fail=2'b11, fail_valid=1, pass=0.
- dut_out stuck-at-1 -> err_count=3, first_fail=2'b00, pass=0.
- TRUTH=4'b1110 (OR) with correct OR model -> pass=1. Same OR model against default AND TRUTH -> err_count=2, first_fail=2'b01.
- start re-pulsed mid-run at cycle 6 -> ignored; run length and results unchanged. Reset asserted at cycle 9 -> outputs immediately at reset values, no done pulse. A new start afterwards completes normally.
- HOLD_CYCLES=1, N_IN=3, TRUTH=8'h80, correct 3-input AND model -> 8 busy cycles, Gray order 000,001,011,010,110,111,101,100, pass=1.

Source files
------------

// File: rtl/gate_truth_checker_pkg.sv
// gate_truth_checker_pkg: run-state encoding and Gray encoder shared by gate checkers
package gate_truth_checker_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, FINISH = 2'd2} state_t;
  function automatic logic [3:0] gray(input logic [3:0] v);
    return v ^ (v >> 1);
  endfunction
endpackage

// File: rtl/gate_truth_checker_hold_timer.sv
// hold_timer: settle counter (clk, reset, en, clear) pulsing tc on the HOLD_CYCLES-th enabled clock
module hold_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tc
);
  localparam int W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  logic [W-1:0] cnt;
  assign tc = en && cnt == W'(HOLD_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clear || tc) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: Gray-walks all gate inputs (stim), samples dut_out after a settle time, reports busy/done/pass/err_count/first_fail/fail_valid
module gate_truth_checker
  import gate_truth_checker_pkg::*;
#(
  parameter int                  N_IN        = 2,
  parameter logic [2**N_IN-1:0]  TRUTH       = 4'b1000,
  parameter int                  HOLD_CYCLES = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [7:0]      err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_valid
);
  state_t state, state_nxt;
  logic [N_IN-1:0] idx, g;
  logic tc, mismatch, last;
  logic [7:0] err_nxt;
  assign g = N_IN'(gray(4'(idx)));
  assign busy = state == DRIVE;
  assign done = state == FINISH;
  assign stim = busy ? g : '0;
  assign mismatch = dut_out != TRUTH[stim];
  assign last = &idx;
  assign err_nxt = (mismatch && err_count != 8'd255) ? err_count + 8'd1 : err_count;
  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk(clk), .reset(reset), .en(busy), .clear(!busy), .tc(tc)
  );
  always_comb
    state_nxt = state == IDLE  ? (start ? DRIVE : IDLE)
              : state == DRIVE ? ((tc && last) ? FINISH : DRIVE)
              : IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx        <= '0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
      pass       <= 1'b0;
    end else if (state == IDLE && start) begin
      idx        <= '0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
      pass       <= 1'b0;
    end else if (tc) begin
      err_count <= err_nxt;
      if (mismatch && !fail_valid) begin
        first_fail <= stim;
        fail_valid <= 1'b1;
      end
      // pass is decided on the final sample so it is already valid while done is high
      if (last) pass <= err_nxt == 8'd0;
      else idx <= idx + 1'b1;
    end
endmodule
